// File: rtl/bp_resolve_queue_pkg.sv
// Shared branch-prediction types and helpers: the in-flight entry layout,
// the sequential PC step, and the prediction-versus-outcome compare.
package bp_resolve_queue_pkg;

    localparam logic [31:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] pred_target;
    } bp_entry_t;

    // A prediction is wrong if the direction differs, or if both agree on
    // taken but the predicted target does not match the real one. The
    // predicted target is irrelevant for a correct not-taken prediction.
    function automatic logic is_mispredict(input bp_entry_t  entry,
                                           input logic       taken,
                                           input logic [31:0] target);
        logic mis;
        mis = 1'b0;
        if (entry.pred_taken != taken) begin
            mis = 1'b1;
        end else if (taken && (entry.pred_target != target)) begin
            mis = 1'b1;
        end else begin
            mis = 1'b0;
        end
        return mis;
    endfunction

endpackage

// File: rtl/bp_entry_fifo.sv
// Pointer-based in-order storage for in-flight branch entries.
// 'discard' empties the queue by moving the write pointer onto the read
// pointer as it stands after any same-cycle pop.
module bp_entry_fifo
    import bp_resolve_queue_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int PTR_BITS = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  bp_entry_t           push_data,
    input  logic                pop,
    input  logic                discard,
    output bp_entry_t           pop_data,
    output logic [PTR_BITS:0]   count
);

    bp_entry_t           mem_r [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr_r;
    logic [PTR_BITS-1:0] rd_ptr_r;
    logic [PTR_BITS:0]   count_r;
    logic [PTR_BITS-1:0] rd_next_s;
    logic [PTR_BITS-1:0] wr_next_s;
    logic [PTR_BITS:0]   count_next_s;

    assign pop_data = mem_r[rd_ptr_r];
    assign count    = count_r;

    // Next pointer and occupancy values; discard overrides push/pop accounting.
    always_comb begin
        rd_next_s    = rd_ptr_r;
        wr_next_s    = wr_ptr_r;
        count_next_s = count_r;
        if (pop) begin
            rd_next_s = rd_ptr_r + PTR_BITS'(1);
        end else begin
            rd_next_s = rd_ptr_r;
        end
        if (discard) begin
            wr_next_s    = rd_next_s;
            count_next_s = {(PTR_BITS+1){1'b0}};
        end else begin
            if (push) begin
                wr_next_s = wr_ptr_r + PTR_BITS'(1);
            end else begin
                wr_next_s = wr_ptr_r;
            end
            case ({push, pop})
                2'b10:   count_next_s = count_r + (PTR_BITS+1)'(1);
                2'b01:   count_next_s = count_r - (PTR_BITS+1)'(1);
                default: count_next_s = count_r;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_BITS{1'b0}};
            rd_ptr_r <= {PTR_BITS{1'b0}};
            count_r  <= {(PTR_BITS+1){1'b0}};
        end else begin
            wr_ptr_r <= wr_next_s;
            rd_ptr_r <= rd_next_s;
            count_r  <= count_next_s;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push && !discard) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/bp_resolve_queue.sv
// In-order branch resolve tracker. Holds fetch-time predictions, compares
// the oldest one against the execute outcome, and emits a one-cycle
// predictor update plus a redirect on mispredict (discarding younger work).
module bp_resolve_queue
    import bp_resolve_queue_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int PTR_BITS = $clog2(DEPTH),
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push_en_i,
    input  logic [31:0]         push_pc_i,
    input  logic                push_pred_taken_i,
    input  logic [31:0]         push_pred_target_i,
    input  logic                resolve_en_i,
    input  logic                resolve_taken_i,
    input  logic [31:0]         resolve_target_i,
    input  logic                flush_i,
    output logic                full_o,
    output logic                empty_o,
    output logic                update_en_o,
    output logic [31:0]         update_pc_o,
    output logic                update_taken_o,
    output logic                mispredict_o,
    output logic [31:0]         redirect_pc_o,
    output logic [CNT_BITS-1:0] mispredict_cnt_o,
    output logic                err_o
);

    bp_entry_t           push_entry_s;
    bp_entry_t           head_s;
    logic [PTR_BITS:0]   count_s;
    logic                full_s;
    logic                empty_s;
    logic                resolve_ok_s;
    logic                mis_s;
    logic                push_ok_s;
    logic                err_set_s;
    logic [31:0]         redirect_s;

    logic                update_en_r;
    logic [31:0]         update_pc_r;
    logic                update_taken_r;
    logic                mispredict_r;
    logic [31:0]         redirect_pc_r;
    logic [CNT_BITS-1:0] cnt_r;
    logic                err_r;

    assign push_entry_s = '{pc: push_pc_i, pred_taken: push_pred_taken_i,
                            pred_target: push_pred_target_i};

    bp_entry_fifo #(
        .DEPTH    (DEPTH),
        .PTR_BITS (PTR_BITS)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_ok_s),
        .push_data (push_entry_s),
        .pop       (resolve_ok_s),
        .discard   (flush_i | mis_s),
        .pop_data  (head_s),
        .count     (count_s)
    );

    // Occupancy flags come straight from the count (pre-resolve view).
    always_comb begin
        full_s  = (count_s == (PTR_BITS+1)'(DEPTH));
        empty_s = (count_s == {(PTR_BITS+1){1'b0}});
    end

    assign full_o  = full_s;
    assign empty_o = empty_s;

    // Resolve qualification, compare, wrong-path push suppression and error detection.
    always_comb begin
        resolve_ok_s = 1'b0;
        mis_s        = 1'b0;
        push_ok_s    = 1'b0;
        err_set_s    = 1'b0;
        redirect_s   = 32'h0000_0000;
        if (flush_i) begin
            resolve_ok_s = 1'b0;
            mis_s        = 1'b0;
            push_ok_s    = 1'b0;
            err_set_s    = 1'b0;
        end else begin
            resolve_ok_s = resolve_en_i && !empty_s;
            mis_s        = resolve_ok_s &&
                           is_mispredict(head_s, resolve_taken_i, resolve_target_i);
            // A push alongside a mispredict is wrong-path work, not an overflow.
            push_ok_s    = push_en_i && !full_s && !mis_s;
            err_set_s    = (push_en_i && full_s && !mis_s) ||
                           (resolve_en_i && empty_s);
        end
        if (resolve_taken_i) begin
            redirect_s = resolve_target_i;
        end else begin
            redirect_s = head_s.pc + PC_STEP;
        end
    end

    // Registered update/redirect pulses, statistics and sticky error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            update_en_r    <= 1'b0;
            update_pc_r    <= 32'h0000_0000;
            update_taken_r <= 1'b0;
            mispredict_r   <= 1'b0;
            redirect_pc_r  <= 32'h0000_0000;
            cnt_r          <= {CNT_BITS{1'b0}};
            err_r          <= 1'b0;
        end else begin
            update_en_r  <= resolve_ok_s;
            mispredict_r <= mis_s;
            if (resolve_ok_s) begin
                update_pc_r    <= head_s.pc;
                update_taken_r <= resolve_taken_i;
            end else begin
                update_pc_r    <= update_pc_r;
                update_taken_r <= update_taken_r;
            end
            if (mis_s) begin
                redirect_pc_r <= redirect_s;
            end else begin
                redirect_pc_r <= redirect_pc_r;
            end
            if (mis_s && (cnt_r != {CNT_BITS{1'b1}})) begin
                cnt_r <= cnt_r + CNT_BITS'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            if (err_set_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign update_en_o      = update_en_r;
    assign update_pc_o      = update_pc_r;
    assign update_taken_o   = update_taken_r;
    assign mispredict_o     = mispredict_r;
    assign redirect_pc_o    = redirect_pc_r;
    assign mispredict_cnt_o = cnt_r;
    assign err_o            = err_r;

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Bench for bp_resolve_queue: directed stimulus pushes hand-computed update
// expectations into a scoreboard; a negedge monitor pops them on each pulse.
module tb_bp_resolve_queue;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic        mis;
        logic [31:0] redirect;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        push_en_i, push_pred_taken_i, resolve_en_i, resolve_taken_i, flush_i;
    logic [31:0] push_pc_i, push_pred_target_i, resolve_target_i;
    logic        full_o, empty_o, update_en_o, update_taken_o, mispredict_o, err_o;
    logic [31:0] update_pc_o, redirect_pc_o;
    logic [15:0] mispredict_cnt_o;

    // second instance with a narrow statistics counter
    logic        p2_push_en, p2_pred_taken, p2_resolve_en, p2_resolve_taken;
    logic [31:0] p2_pc, p2_pred_target, p2_resolve_target;
    logic        p2_full, p2_empty, p2_update_en, p2_update_taken, p2_mispredict, p2_err;
    logic [31:0] p2_update_pc, p2_redirect_pc;
    logic [1:0]  p2_cnt;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    bp_resolve_queue #(.DEPTH(4), .CNT_BITS(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .push_en_i(push_en_i), .push_pc_i(push_pc_i),
        .push_pred_taken_i(push_pred_taken_i), .push_pred_target_i(push_pred_target_i),
        .resolve_en_i(resolve_en_i), .resolve_taken_i(resolve_taken_i),
        .resolve_target_i(resolve_target_i), .flush_i(flush_i),
        .full_o(full_o), .empty_o(empty_o), .update_en_o(update_en_o),
        .update_pc_o(update_pc_o), .update_taken_o(update_taken_o),
        .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o),
        .mispredict_cnt_o(mispredict_cnt_o), .err_o(err_o)
    );

    bp_resolve_queue #(.DEPTH(4), .CNT_BITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .push_en_i(p2_push_en), .push_pc_i(p2_pc),
        .push_pred_taken_i(p2_pred_taken), .push_pred_target_i(p2_pred_target),
        .resolve_en_i(p2_resolve_en), .resolve_taken_i(p2_resolve_taken),
        .resolve_target_i(p2_resolve_target), .flush_i(1'b0),
        .full_o(p2_full), .empty_o(p2_empty), .update_en_o(p2_update_en),
        .update_pc_o(p2_update_pc), .update_taken_o(p2_update_taken),
        .mispredict_o(p2_mispredict), .redirect_pc_o(p2_redirect_pc),
        .mispredict_cnt_o(p2_cnt), .err_o(p2_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        push_en_i = 1'b0; push_pc_i = 32'h0; push_pred_taken_i = 1'b0; push_pred_target_i = 32'h0;
        resolve_en_i = 1'b0; resolve_taken_i = 1'b0; resolve_target_i = 32'h0; flush_i = 1'b0;
    endtask

    task automatic set_push(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
        push_en_i = 1'b1; push_pc_i = pc; push_pred_taken_i = pt; push_pred_target_i = tgt;
    endtask

    task automatic set_resolve(input logic tk, input logic [31:0] tgt);
        resolve_en_i = 1'b1; resolve_taken_i = tk; resolve_target_i = tgt;
    endtask

    task automatic expect_upd(input logic [31:0] pc, input logic tk, input logic mis,
                              input logic [31:0] red, input logic [15:0] cnt);
        exp_t e;
        e.pc = pc; e.taken = tk; e.mis = mis; e.redirect = red; e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic do_push(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
        set_push(pc, pt, tgt);
        tick();
        idle_inputs();
    endtask

    task automatic do_resolve(input logic tk, input logic [31:0] tgt, input logic [31:0] epc,
                              input logic emis, input logic [31:0] ered, input logic [15:0] ecnt);
        set_resolve(tk, tgt);
        expect_upd(epc, tk, emis, ered, ecnt);
        tick();
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Monitor: every update/mispredict pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (update_en_o || mispredict_o) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_pulse: got update_en=%0b mispredict=%0b pc=0x%0h expected no pulse",
                         update_en_o, mispredict_o, update_pc_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("upd_en", {31'd0, update_en_o}, 32'd1);
                chk("upd_pc", update_pc_o, e.pc);
                chk("upd_taken", {31'd0, update_taken_o}, {31'd0, e.taken});
                chk("mispredict", {31'd0, mispredict_o}, {31'd0, e.mis});
                chk("mis_cnt", {16'd0, mispredict_cnt_o}, {16'd0, e.cnt});
                if (e.mis) chk("redirect_pc", redirect_pc_o, e.redirect);
            end
        end
    end

    initial begin
        idle_inputs();
        p2_push_en = 1'b0; p2_pc = 32'h0; p2_pred_taken = 1'b0; p2_pred_target = 32'h0;
        p2_resolve_en = 1'b0; p2_resolve_taken = 1'b0; p2_resolve_target = 32'h0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // reset state
        chk("rst_update_en", {31'd0, update_en_o}, 32'd0);
        chk("rst_update_pc", update_pc_o, 32'd0);
        chk("rst_update_taken", {31'd0, update_taken_o}, 32'd0);
        chk("rst_mispredict", {31'd0, mispredict_o}, 32'd0);
        chk("rst_redirect", redirect_pc_o, 32'd0);
        chk("rst_cnt", {16'd0, mispredict_cnt_o}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        chk("rst_empty", {31'd0, empty_o}, 32'd1);
        chk("rst_full", {31'd0, full_o}, 32'd0);

        // correct taken prediction
        do_push(32'h100, 1'b1, 32'h200);
        chk("one_empty", {31'd0, empty_o}, 32'd0);
        do_resolve(1'b1, 32'h200, 32'h100, 1'b0, 32'h0, 16'd0);
        chk("after_ok_empty", {31'd0, empty_o}, 32'd1);

        // push and resolve together, not full: occupancy unchanged
        do_push(32'h110, 1'b1, 32'h210);
        set_push(32'h120, 1'b0, 32'h0);
        set_resolve(1'b1, 32'h210);
        expect_upd(32'h110, 1'b1, 1'b0, 32'h0, 16'd0);
        tick();
        idle_inputs();
        chk("pushres_empty", {31'd0, empty_o}, 32'd0);
        do_resolve(1'b0, 32'h0, 32'h120, 1'b0, 32'h0, 16'd0);
        chk("pushres_drained", {31'd0, empty_o}, 32'd1);

        // mispredicts: direction (both ways) and target mismatch
        do_push(32'h100, 1'b0, 32'h0);
        do_resolve(1'b1, 32'h400, 32'h100, 1'b1, 32'h400, 16'd1);
        do_push(32'h100, 1'b1, 32'h200);
        do_resolve(1'b0, 32'h0, 32'h100, 1'b1, 32'h104, 16'd2);
        do_push(32'h180, 1'b1, 32'h200);
        do_resolve(1'b1, 32'h240, 32'h180, 1'b1, 32'h240, 16'd3);
        do_push(32'hFFFF_FFFC, 1'b1, 32'h10);
        do_resolve(1'b0, 32'h0, 32'hFFFF_FFFC, 1'b1, 32'h0, 16'd4);

        // fill, overflow, drain in order
        for (int i = 1; i <= 4; i++) do_push(32'(i * 16), 1'b1, 32'(i * 16 + 32'h1000));
        chk("fill_full", {31'd0, full_o}, 32'd1);
        chk("fill_err", {31'd0, err_o}, 32'd0);
        do_push(32'h50, 1'b1, 32'h0);
        chk("overflow_err", {31'd0, err_o}, 32'd1);
        chk("overflow_full", {31'd0, full_o}, 32'd1);
        for (int i = 1; i <= 4; i++)
            do_resolve(1'b1, 32'(i * 16 + 32'h1000), 32'(i * 16), 1'b0, 32'h0, 16'd4);
        chk("drain_empty", {31'd0, empty_o}, 32'd1);

        // mispredict with same-cycle push discards younger work
        do_reset();
        do_push(32'hA0, 1'b0, 32'h0);
        do_push(32'hB0, 1'b0, 32'h0);
        do_push(32'hC0, 1'b0, 32'h0);
        set_push(32'hD0, 1'b0, 32'h0);
        set_resolve(1'b1, 32'h800);
        expect_upd(32'hA0, 1'b1, 1'b1, 32'h800, 16'd1);
        tick();
        idle_inputs();
        chk("mis_discard_empty", {31'd0, empty_o}, 32'd1);
        chk("mis_push_no_err", {31'd0, err_o}, 32'd0);
        set_resolve(1'b1, 32'h0);
        tick();
        idle_inputs();
        chk("resolve_empty_err", {31'd0, err_o}, 32'd1);

        // flush with same-cycle resolve and push
        do_reset();
        do_push(32'h300, 1'b1, 32'h900);
        do_push(32'h304, 1'b1, 32'h900);
        set_push(32'h777, 1'b1, 32'h0);
        set_resolve(1'b1, 32'h900);
        flush_i = 1'b1;
        tick();
        idle_inputs();
        chk("flush_empty", {31'd0, empty_o}, 32'd1);
        chk("flush_no_err", {31'd0, err_o}, 32'd0);
        tick();
        do_push(32'h500, 1'b1, 32'h900);
        do_resolve(1'b1, 32'h900, 32'h500, 1'b0, 32'h0, 16'd0);

        // full: same-cycle resolve does not make room for a push
        for (int i = 1; i <= 4; i++) do_push(32'(i * 16), 1'b1, 32'(i * 16 + 32'h1000));
        set_push(32'h99, 1'b1, 32'h0);
        set_resolve(1'b1, 32'h1010);
        expect_upd(32'h10, 1'b1, 1'b0, 32'h0, 16'd0);
        tick();
        idle_inputs();
        chk("full_pushres_err", {31'd0, err_o}, 32'd1);
        chk("full_pushres_full", {31'd0, full_o}, 32'd0);
        do_resolve(1'b1, 32'h1020, 32'h20, 1'b0, 32'h0, 16'd0);
        do_resolve(1'b1, 32'h1030, 32'h30, 1'b0, 32'h0, 16'd0);

        // reset mid-stream with a pending resolve: no pulse, all cleared
        rst_n = 1'b0;
        set_resolve(1'b0, 32'h0);
        tick();
        idle_inputs();
        rst_n = 1'b1;
        chk("midrst_update_en", {31'd0, update_en_o}, 32'd0);
        chk("midrst_update_pc", update_pc_o, 32'd0);
        chk("midrst_mispredict", {31'd0, mispredict_o}, 32'd0);
        chk("midrst_err", {31'd0, err_o}, 32'd0);
        chk("midrst_empty", {31'd0, empty_o}, 32'd1);
        tick();

        // narrow counter saturates at all-ones
        for (int i = 1; i <= 5; i++) begin
            p2_push_en = 1'b1; p2_pc = 32'(i * 16); p2_pred_taken = 1'b0;
            tick();
            p2_push_en = 1'b0;
            p2_resolve_en = 1'b1; p2_resolve_taken = 1'b1; p2_resolve_target = 32'h40;
            tick();
            p2_resolve_en = 1'b0;
            chk("sat_mispredict", {31'd0, p2_mispredict}, 32'd1);
            chk("sat_cnt", {30'd0, p2_cnt}, (i < 3) ? 32'(i) : 32'd3);
        end

        tick();
        tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
